// File: rtl/mem_access_unit.sv
// Memory-access stage: effective-address loads/stores over a req/ack data port, write-back packet out.
// Optional MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES without dmem_ack (fault_code 11).
//
// state   | meaning
// IDLE    | ready for a new op; decodes, faults or passes through in one cycle
// REQ     | memory request outstanding, dmem_* held until ack (or timeout)
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [63:0] alu_result,
   input  logic [63:0] store_data,
   input  logic [4:0]  rd_in,
   input  logic        reg_write_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [60:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        wb_valid,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t      state_q;
   logic        dmem_req_q, dmem_we_q;
   logic [60:0] dmem_addr_q;
   logic [63:0] dmem_wdata_q;
   logic [7:0]  dmem_wstrb_q;
   logic        wb_valid_q, wb_reg_write_q, fault_q;
   logic [63:0] wb_data_q;
   logic [4:0]  wb_rd_q;
   logic [1:0]  fault_code_q;
   logic [2:0]  lane_q;
   logic [1:0]  size_q;
   logic        unsigned_q, is_load_q, reg_write_q;

   logic        illegal_d, misalign_d;
   logic [7:0]  mask_d, wstrb_d;
   logic [63:0] wdata_d, lane_data, ld_data_d;

`ifdef MEM_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMR_W-1:0] tmr_q;
`endif

   always_comb begin
      illegal_d = (mem_read && mem_write) || (mem_read && funct3 == 3'b111)
                  || (mem_write && funct3[2]);
      misalign_d = 1'b0;
      mask_d     = 8'h01;
      unique case (funct3[1:0])
         2'b00: begin misalign_d = 1'b0;               mask_d = 8'h01; end
         2'b01: begin misalign_d = alu_result[0];      mask_d = 8'h03; end
         2'b10: begin misalign_d = |alu_result[1:0];   mask_d = 8'h0F; end
         default: begin misalign_d = |alu_result[2:0]; mask_d = 8'hFF; end
      endcase
      wstrb_d = mem_write ? (mask_d << alu_result[2:0]) : 8'h00;
      wdata_d = mem_write ? (store_data << {alu_result[2:0], 3'b000}) : 64'd0;
   end

   always_comb begin
      lane_data = dmem_rdata >> {lane_q, 3'b000};
      ld_data_d = lane_data;
      unique case (size_q)
         2'b00: ld_data_d = unsigned_q ? {56'd0, lane_data[7:0]}
                                       : {{56{lane_data[7]}}, lane_data[7:0]};
         2'b01: ld_data_d = unsigned_q ? {48'd0, lane_data[15:0]}
                                       : {{48{lane_data[15]}}, lane_data[15:0]};
         2'b10: ld_data_d = unsigned_q ? {32'd0, lane_data[31:0]}
                                       : {{32{lane_data[31]}}, lane_data[31:0]};
         default: ld_data_d = lane_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         dmem_wstrb_q   <= '0;
         wb_valid_q     <= 1'b0;
         wb_data_q      <= '0;
         wb_rd_q        <= '0;
         wb_reg_write_q <= 1'b0;
         fault_q        <= 1'b0;
         fault_code_q   <= 2'b00;
         lane_q         <= '0;
         size_q         <= '0;
         unsigned_q     <= 1'b0;
         is_load_q      <= 1'b0;
         reg_write_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         tmr_q          <= '0;
`endif
      end else begin
         wb_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  wb_rd_q <= rd_in;
                  if ((mem_read || mem_write) && (illegal_d || misalign_d)) begin
                     wb_valid_q     <= 1'b1;
                     fault_q        <= 1'b1;
                     fault_code_q   <= illegal_d ? 2'b10 : 2'b01;
                     wb_reg_write_q <= 1'b0;
                  end else if (!mem_read && !mem_write) begin
                     wb_valid_q     <= 1'b1;
                     wb_data_q      <= alu_result;
                     wb_reg_write_q <= reg_write_in;
                     fault_code_q   <= 2'b00;
                  end else begin
                     state_q      <= ST_REQ;
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= mem_write;
                     dmem_addr_q  <= alu_result[63:3];
                     dmem_wstrb_q <= wstrb_d;
                     dmem_wdata_q <= wdata_d;
                     lane_q       <= alu_result[2:0];
                     size_q       <= funct3[1:0];
                     unsigned_q   <= funct3[2];
                     is_load_q    <= mem_read;
                     reg_write_q  <= reg_write_in;
`ifdef MEM_TIMEOUT_EN
                     tmr_q        <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                  end
               end
            end
            ST_REQ: begin
               if (dmem_ack) begin
                  state_q        <= ST_IDLE;
                  dmem_req_q     <= 1'b0;
                  dmem_we_q      <= 1'b0;
                  wb_valid_q     <= 1'b1;
                  wb_data_q      <= is_load_q ? ld_data_d : 64'd0;
                  wb_reg_write_q <= is_load_q && reg_write_q;
                  fault_code_q   <= 2'b00;
`ifdef MEM_TIMEOUT_EN
               end else if (tmr_q == '0) begin
                  // terminal count reached: abandon the access, late acks fall into IDLE and are ignored
                  state_q        <= ST_IDLE;
                  dmem_req_q     <= 1'b0;
                  dmem_we_q      <= 1'b0;
                  wb_valid_q     <= 1'b1;
                  fault_q        <= 1'b1;
                  fault_code_q   <= 2'b11;
                  wb_reg_write_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign dmem_wstrb   = dmem_wstrb_q;
   assign wb_valid     = wb_valid_q;
   assign wb_data      = wb_data_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign fault        = fault_q;
   assign fault_code   = fault_code_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-access stage directly downstream of the execute stage in the sequential RV64 core. Consumes the ALU result as the effective address, performs byte/half/word/double loads and stores over a req/ack data-memory handshake, and hands a write-back packet to the register-file write stage. Stalls upstream via in_ready while a memory transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, cycles in REQ without dmem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute result valid
in_ready  output  1  stage can accept (high only in IDLE)
mem_read  input  1  load instruction
mem_write  input  1  store instruction
funct3  input  3  access size/sign (RV64 load/store encoding)
alu_result  input  64  effective address, or result for non-memory ops
store_data  input  64  rs2 value for stores
rd_in  input  5  destination register
reg_write_in  input  1  instruction writes rd
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  61  doubleword address (alu_result[63:3])
dmem_wdata  output  64  lane-aligned store data
dmem_wstrb  output  8  byte enables
dmem_ack  input  1  request complete; rdata valid same cycle for reads
dmem_rdata  input  64  doubleword read data
wb_valid  output  1  one-cycle pulse: write-back packet valid
wb_data  output  64  load result or passed-through alu_result
wb_rd  output  5  destination register
wb_reg_write  output  1  rd write enable (forced 0 on fault)
fault  output  1  one-cycle pulse with wb_valid on misaligned/illegal/timeout
fault_code  output  2  00 none, 01 misaligned, 10 illegal, 11 timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, fault = 0; dmem_addr, dmem_wdata, dmem_wstrb, wb_data, wb_rd, fault_code = 0. Reset mid-transaction drops dmem_req immediately, discarding the access.
- States: IDLE, REQ. in_ready = (state==IDLE). Accept = in_valid && in_ready at a rising edge.
- Accept, neither mem_read nor mem_write: no memory access; next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd_in, wb_reg_write=reg_write_in. Stays IDLE.
- Accept, mem_read && mem_write, or load funct3=111, or store funct3[2]=1: illegal; next cycle wb_valid=1, fault=1, fault_code=10, wb_reg_write=0.
- Misaligned if halfword addr[0]!=0, word addr[1:0]!=0, doubleword addr[2:0]!=0: next cycle wb_valid=1, fault=1, fault_code=01, wb_reg_write=0, no request. Illegal takes priority over misaligned.
- Valid access: registers address, size, sign, rd; enters REQ; dmem_req=1 from the cycle after accept. dmem_we=mem_write. dmem_wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]. dmem_wdata = store_data << (8*addr[2:0]). Loads drive wstrb=0 and wdata=0.
- REQ: all dmem_* outputs held stable until dmem_ack sampled high. On ack: dmem_req=0 and state IDLE at the same edge. wb_valid=1 on the following cycle.
- Load extraction: byte lane = rdata >> (8*addr[2:0]). LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD takes all 64 bits. Stores produce wb_reg_write=0.
- Latency: non-memory or fault = 1 cycle accept->wb_valid. Memory = 2 + N cycles, where N = cycles waited for ack.
- dmem_ack outside REQ is ignored. wb_* and fault_code hold their values between pulses. wb_valid and fault are one cycle wide.
- Back-to-back: a new accept is possible in the same cycle wb_valid pulses for the previous op.

Optional Feature:
MEM_TIMEOUT_EN. Defined: a counter clears on entry to REQ and increments each REQ cycle. If it reaches TIMEOUT_CYCLES without ack, dmem_req drops, state returns to IDLE, and the next cycle gives wb_valid=1, fault=1, fault_code=11, wb_reg_write=0. A late ack is ignored. Undefined: no counter; REQ waits indefinitely; fault_code 11 is never produced.

Test Plan:
- ADD pass-through: alu_result=0x1234, rd=5, reg_write=1 -> wb_valid next cycle, wb_data=0x1234, wb_rd=5, no dmem_req.
- SB addr 0x1003, store_data=0xAB -> dmem_addr=0x200, wstrb=0x08, wdata=0xAB000000, dmem_we=1 held until ack; wb_reg_write=0.
- LB addr 0x1005, rdata=0x0000_8000_0000_0000, ack after 3 cycles -> wb_data=0xFFFF_FFFF_FFFF_FF80. Same access with LBU -> 0x80. wb_valid exactly 5 cycles after accept.
- LW addr 0x1002 -> no request, wb_valid next cycle, fault=1, fault_code=01, wb_reg_write=0. funct3=111 load -> fault_code=10.
- LD addr 0x2000 with rdata=0x0123456789ABCDEF, ack same cycle as req -> wb_data=0x0123456789ABCDEF; rst_n pulsed low while in REQ on a second access -> dmem_req=0 immediately, no wb_valid.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> dmem_req high for exactly 4 cycles, then fault_code=11 pulse; in_ready returns to 1.
